result_checker: RTL and testbench
=================================

Name: result_checker

Overview:
- Hardware self-check engine for processor bring-up. It replaces bench-side checks of register-file and data-memory contents after the core signals done.
- After start, it waits for the core's done, with a cycle counter and a programmable timeout watchdog. It then scans up to NCHK configured locations through a read port and compares each against a masked expected value. It reports pass/fail, a per-entry error vector and the run length.
- Sits beside top_level and connects to a debug read port muxed onto the register file or data memory.

Parameters:
DW, 8, data width of checked locations
AW, 8, address width of the read port
NCHK, 4, number of check-table entries (>=1)
CW, 16, width of cycle counter and timeout limit
RD_LAT, 1, read latency of the target port: 0 (combinational) or 1 (registered)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; accepted only when busy=0
timeout_limit  in  CW  max RUN cycles before timeout; 0 disables the watchdog; sampled on accepted start
cfg_we  in  1  write one check-table entry; ignored while busy=1
cfg_idx  in  $clog2(NCHK) (min 1)  entry index; writes with idx>=NCHK are ignored
cfg_valid  in  1  entry enable
cfg_addr  in  AW  location to read
cfg_exp  in  DW  expected value
cfg_mask  in  DW  compare mask; 1 = bit is compared
dut_done  in  1  core done flag (level)
rd_en  out  1  read request to target
rd_addr  out  AW  read address
rd_data  in  DW  read data
busy  out  1  high from accepted start until REPORT
pass  out  1  run finished with no timeout and no mismatch
fail  out  1  run finished with timeout or at least one mismatch
timeout  out  1  watchdog expired
err_vec  out  NCHK  bit i = entry i mismatched
err_count  out  $clog2(NCHK+1)  number of mismatching entries
cycles  out  CW  RUN cycles counted before done or timeout

Behaviour:
- Reset: state IDLE. All outputs 0: busy, pass, fail, timeout, err_vec, err_count, cycles, rd_en, rd_addr. All table valid bits are cleared. Reset mid-run aborts immediately, with no report.
- States: IDLE, RUN, SCAN_ISSUE, SCAN_WAIT (used only when RD_LAT=1), REPORT.
- IDLE/REPORT + start=1: go to RUN.
  - cycles, err_vec, err_count, pass, fail and timeout are cleared.
  - busy=1 from the next cycle.
  - timeout_limit is latched.
- start while busy: ignored.
- RUN, each cycle:
  - If dut_done=1: go to SCAN_ISSUE with idx=0. cycles is not incremented.
  - Otherwise, cycles increments, saturating at all-ones.
  - If limit!=0 and the incremented value equals the limit: timeout=1, go to REPORT. No scan is performed.
  - dut_done in the same cycle as an accepted start is not seen. It is first sampled in RUN.
- SCAN_ISSUE, entry idx:
  - If valid[idx]=0: one cycle, no rd_en, no compare.
  - If valid[idx]=1: rd_en=1 and rd_addr=addr[idx] for exactly one cycle.
  - RD_LAT=0: rd_data is compared in the same cycle.
  - RD_LAT=1: go to SCAN_WAIT; rd_data is compared there on the following cycle, with rd_en=0.
- Compare: mismatch when (rd_data & mask) != (exp & mask). A mismatch sets err_vec[idx] and increments err_count.
- Advance: after entry NCHK-1, go to REPORT. Otherwise idx+1 returns to SCAN_ISSUE.
- REPORT:
  - busy=0.
  - fail = timeout | (err_count!=0).
  - pass = !fail.
  - All result outputs hold until the next accepted start or reset. pass and fail are never both 1.
- rd_en=0 and rd_addr=0 outside SCAN_ISSUE.
- Table writes are ignored while busy=1, so the scan always uses a stable table. A write in the REPORT or IDLE state takes effect on the next clock.
- Entries with mask=0 always match.
- No valid entries: after done, NCHK scan cycles with no rd_en, then pass=1.

Test Plan:
1. NCHK=4, RD_LAT=1. Entries 0:{addr 0, exp 0x07, mask 0xFF} and 1:{addr 1, exp 0x07, mask 0xFF}; entries 2-3 invalid. Start; dut_done rises after 20 RUN cycles; target returns 0x07 for both.
   -> cycles=20, rd_en pulses at addr 0 then addr 1, pass=1, err_vec=0, err_count=0.
2. Same as 1, but addr 1 returns 0x05.
   -> fail=1, pass=0, err_vec=4'b0010, err_count=1, timeout=0.
3. Entry 0:{exp 0x80, mask 0xF0}; target returns 0x85.
   -> pass=1. Repeat with RD_LAT=0 -> pass=1 and a scan shorter by one cycle per valid entry.
4. timeout_limit=50 and dut_done held 0.
   -> timeout=1 and fail=1 exactly 50 cycles after the accepted start, cycles=50, rd_en never asserted.
5. Assert reset during SCAN_WAIT.
   -> next cycle all outputs 0 and the table invalid. A new start with done at once gives pass=1 and no rd_en.
6. Pulse start and cfg_we while busy.
   -> both ignored: run length, table contents and results are unchanged from the undisturbed run.

Source files
------------

// File: rtl/result_checker_if.sv
// Debug read port from the checker to a register file or data memory.
// rd_data returns either combinationally or one cycle after rd_en; no stall path.
interface result_checker_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/result_checker.sv
// Bring-up self-check: waits for core done under a watchdog, then scans a masked check table.
// One read per valid entry (plus a wait cycle when RD_LAT=1); the target cannot stall a read.
module result_checker #(
  parameter int DW     = 8,
  parameter int AW     = 8,
  parameter int NCHK   = 4,
  parameter int CW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [CW-1:0]                           timeout_limit,
  input  logic                                    cfg_we,
  input  logic [((NCHK > 1) ? $clog2(NCHK) : 1)-1:0] cfg_idx,
  input  logic                                    cfg_valid,
  input  logic [AW-1:0]                           cfg_addr,
  input  logic [DW-1:0]                           cfg_exp,
  input  logic [DW-1:0]                           cfg_mask,
  input  logic                                    dut_done,
  result_checker_if.master                        rd,
  output logic                                    busy,
  output logic                                    pass,
  output logic                                    fail,
  output logic                                    timeout,
  output logic [NCHK-1:0]                         err_vec,
  output logic [$clog2(NCHK+1)-1:0]               err_count,
  output logic [CW-1:0]                           cycles
);

  localparam int IW = (NCHK > 1) ? $clog2(NCHK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHK - 1);

  typedef enum logic [2:0] {IDLE, RUN, SCAN_ISSUE, SCAN_WAIT, REPORT} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [CW-1:0] limit_q;
  logic          rd_en_q;
  logic [AW-1:0] rd_addr_q;

  logic [NCHK-1:0] entry_vld;
  logic [AW-1:0]   entry_addr [NCHK];
  logic [DW-1:0]   entry_exp  [NCHK];
  logic [DW-1:0]   entry_mask [NCHK];

  logic [CW-1:0] cyc_inc;
  logic [IW-1:0] idx_nxt;
  logic          idle_like;
  logic          cmp_now;
  logic          mism;
  logic          step;

  assign rd.rd_en   = rd_en_q;
  assign rd.rd_addr = rd_addr_q;

  always_comb begin
    cyc_inc   = (&cycles) ? cycles : cycles + 1'b1;
    idx_nxt   = idx + 1'b1;
    idle_like = (state == IDLE) || (state == REPORT);
    // Data is valid in the issue cycle for a combinational target, one cycle later otherwise.
    cmp_now   = entry_vld[idx] &&
                ((RD_LAT == 0) ? (state == SCAN_ISSUE) : (state == SCAN_WAIT));
    mism      = cmp_now && (((rd.rd_data ^ entry_exp[idx]) & entry_mask[idx]) != '0);
    // Invalid entries cost a single issue cycle even with a registered target.
    step      = (state == SCAN_WAIT) ||
                ((state == SCAN_ISSUE) && ((RD_LAT == 0) || !entry_vld[idx]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      limit_q   <= '0;
      entry_vld <= '0;
      busy      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      err_vec   <= '0;
      err_count <= '0;
      cycles    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      if (cfg_we && idle_like && (cfg_idx <= LAST)) begin
        entry_vld[cfg_idx]  <= cfg_valid;
        entry_addr[cfg_idx] <= cfg_addr;
        entry_exp[cfg_idx]  <= cfg_exp;
        entry_mask[cfg_idx] <= cfg_mask;
      end

      case (state)
        IDLE, REPORT: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            err_vec   <= '0;
            err_count <= '0;
            cycles    <= '0;
            limit_q   <= timeout_limit;
          end
        end
        RUN: begin
          if (dut_done) begin
            state     <= SCAN_ISSUE;
            idx       <= '0;
            rd_en_q   <= entry_vld[0];
            rd_addr_q <= entry_vld[0] ? entry_addr[0] : '0;
          end else begin
            cycles <= cyc_inc;
            if ((limit_q != '0) && (cyc_inc == limit_q)) begin
              timeout <= 1'b1;
              fail    <= 1'b1;
              busy    <= 1'b0;
              state   <= REPORT;
            end
          end
        end
        SCAN_ISSUE: begin
          rd_en_q   <= 1'b0;
          rd_addr_q <= '0;
          if (!step) state <= SCAN_WAIT;
        end
        default: ;
      endcase

      if (mism) begin
        err_vec[idx] <= 1'b1;
        err_count    <= err_count + 1'b1;
      end

      if (step) begin
        if (idx == LAST) begin
          state <= REPORT;
          busy  <= 1'b0;
          fail  <= mism || (err_count != '0);
          pass  <= !(mism || (err_count != '0));
        end else begin
          idx       <= idx_nxt;
          state     <= SCAN_ISSUE;
          rd_en_q   <= entry_vld[idx_nxt];
          rd_addr_q <= entry_vld[idx_nxt] ? entry_addr[idx_nxt] : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_checker.sv
// Runs a combinational-target and a registered-target checker side by side against
// a memory model, comparing each run with results computed from the table rules.
module tb_result_checker;
  localparam int NCHK = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, cfg_we, cfg_valid, dut_done;
  logic [15:0] timeout_limit;
  logic [1:0]  cfg_idx;
  logic [7:0]  cfg_addr, cfg_exp, cfg_mask;

  logic        busy_o [2];
  logic        pass_o [2];
  logic        fail_o [2];
  logic        timeout_o [2];
  logic [3:0]  err_vec_o [2];
  logic [2:0]  err_count_o [2];
  logic [15:0] cycles_o [2];

  result_checker_if #(.DW(8), .AW(8)) rdif0 ();
  result_checker_if #(.DW(8), .AW(8)) rdif1 ();

  logic [7:0] mem [256];

  assign rdif0.rd_data = rdif0.rd_en ? mem[rdif0.rd_addr] : ~mem[rdif0.rd_addr];
  always @(posedge clk) rdif1.rd_data <= rdif1.rd_en ? mem[rdif1.rd_addr] : 8'($urandom);

  result_checker #(.DW(8), .AW(8), .NCHK(NCHK), .CW(16), .RD_LAT(0)) u_lat0 (
    .clk(clk), .reset(reset), .start(start), .timeout_limit(timeout_limit),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid), .cfg_addr(cfg_addr),
    .cfg_exp(cfg_exp), .cfg_mask(cfg_mask), .dut_done(dut_done), .rd(rdif0),
    .busy(busy_o[0]), .pass(pass_o[0]), .fail(fail_o[0]), .timeout(timeout_o[0]),
    .err_vec(err_vec_o[0]), .err_count(err_count_o[0]), .cycles(cycles_o[0])
  );

  result_checker #(.DW(8), .AW(8), .NCHK(NCHK), .CW(16), .RD_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .start(start), .timeout_limit(timeout_limit),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid), .cfg_addr(cfg_addr),
    .cfg_exp(cfg_exp), .cfg_mask(cfg_mask), .dut_done(dut_done), .rd(rdif1),
    .busy(busy_o[1]), .pass(pass_o[1]), .fail(fail_o[1]), .timeout(timeout_o[1]),
    .err_vec(err_vec_o[1]), .err_count(err_count_o[1]), .cycles(cycles_o[1])
  );

  // Reference copy of the check table.
  bit         m_vld  [NCHK];
  logic [7:0] m_addr [NCHK];
  logic [7:0] m_exp  [NCHK];
  logic [7:0] m_mask [NCHK];

  int checks = 0;
  int failures = 0;

  // Observations from the most recent run.
  int    o_busy [2];
  int    o_bad_addr [2];
  string o_reads [2];

  task automatic write_entry(input int i, input bit v, input logic [7:0] a, e, m);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'(i); cfg_valid = v; cfg_addr = a; cfg_exp = e; cfg_mask = m;
    @(negedge clk);
    cfg_we = 1'b0;
    m_vld[i] = v; m_addr[i] = a; m_exp[i] = e; m_mask[i] = m;
  endtask

  task automatic clear_table();
    for (int i = 0; i < NCHK; i++) write_entry(i, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  // d = RUN cycles with done low before it rises (-1: never); lim = watchdog limit.
  task automatic run_scenario(input string name, input int d, input logic [15:0] lim,
                              input bit disturb);
    bit    timed, finished;
    int    nvalid, nerr, exp_cycles, exp_busy;
    logic  [3:0] exp_vec;
    string exp_reads;
    timed = (lim != 0) && ((d < 0) || (int'(lim) <= d));
    nvalid = 0; nerr = 0; exp_vec = '0; exp_reads = "";
    for (int i = 0; i < NCHK; i++) begin
      if (m_vld[i]) begin
        nvalid++;
        exp_reads = {exp_reads, $sformatf("%02h ", m_addr[i])};
        if (((mem[m_addr[i]] ^ m_exp[i]) & m_mask[i]) != 0) begin
          exp_vec[i] = 1'b1;
          nerr++;
        end
      end
    end
    if (timed) begin
      exp_cycles = int'(lim); exp_vec = '0; nerr = 0; exp_reads = "";
    end else begin
      exp_cycles = d;
    end

    @(negedge clk);
    start = 1'b1; timeout_limit = lim; dut_done = 1'b0;
    o_busy = '{0, 0}; o_bad_addr = '{0, 0}; o_reads = '{"", ""};
    finished = 1'b0;
    for (int k = 0; k < 3000 && !finished; k++) begin
      @(negedge clk);
      start = 1'b0; cfg_we = 1'b0;
      timeout_limit = 16'($urandom);
      dut_done = (d >= 0) && (k >= d);
      for (int l = 0; l < 2; l++) if (busy_o[l]) o_busy[l]++;
      if (rdif0.rd_en) o_reads[0] = {o_reads[0], $sformatf("%02h ", rdif0.rd_addr)};
      else if (rdif0.rd_addr != 0) o_bad_addr[0]++;
      if (rdif1.rd_en) o_reads[1] = {o_reads[1], $sformatf("%02h ", rdif1.rd_addr)};
      else if (rdif1.rd_addr != 0) o_bad_addr[1]++;
      if (disturb && k == 3) begin
        start = 1'b1; timeout_limit = 16'd2;
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_valid = 1'b1; cfg_addr = 8'hEE;
        cfg_exp = ~mem[8'hEE]; cfg_mask = 8'hFF;
      end
      if (k > 0 && !busy_o[0] && !busy_o[1]) finished = 1'b1;
    end
    dut_done = 1'b0;

    checks++;
    if (!finished) begin
      failures++;
      $display("FAIL %s run_end: still busy after 3000 cycles, required REPORT", name);
    end

    for (int l = 0; l < 2; l++) begin
      exp_busy = timed ? int'(lim) : d + 1 + NCHK + ((l == 1) ? nvalid : 0);
      checks++;
      if (pass_o[l] !== (!timed && nerr == 0)) begin
        failures++;
        $display("FAIL %s[lat%0d] pass: got %b required %b", name, l, pass_o[l], !timed && nerr == 0);
      end
      checks++;
      if (fail_o[l] !== (timed || nerr != 0)) begin
        failures++;
        $display("FAIL %s[lat%0d] fail: got %b required %b", name, l, fail_o[l], timed || nerr != 0);
      end
      checks++;
      if (timeout_o[l] !== timed) begin
        failures++;
        $display("FAIL %s[lat%0d] timeout: got %b required %b", name, l, timeout_o[l], timed);
      end
      checks++;
      if (err_vec_o[l] !== exp_vec || err_count_o[l] !== 3'(nerr)) begin
        failures++;
        $display("FAIL %s[lat%0d] errors: got vec=%b cnt=%0d required vec=%b cnt=%0d",
                 name, l, err_vec_o[l], err_count_o[l], exp_vec, nerr);
      end
      checks++;
      if (cycles_o[l] !== 16'(exp_cycles)) begin
        failures++;
        $display("FAIL %s[lat%0d] cycles: got %0d required %0d", name, l, cycles_o[l], exp_cycles);
      end
      checks++;
      if (o_busy[l] != exp_busy) begin
        failures++;
        $display("FAIL %s[lat%0d] busy_len: got %0d required %0d", name, l, o_busy[l], exp_busy);
      end
      checks++;
      if (o_reads[l] != exp_reads || o_bad_addr[l] != 0) begin
        failures++;
        $display("FAIL %s[lat%0d] reads: got '%s' (stray addr %0d) required '%s'",
                 name, l, o_reads[l], o_bad_addr[l], exp_reads);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [35:0] v;
    for (int l = 0; l < 2; l++) begin
      v = {busy_o[l], pass_o[l], fail_o[l], timeout_o[l], err_vec_o[l], err_count_o[l],
           cycles_o[l], (l == 0) ? rdif0.rd_en : rdif1.rd_en,
           (l == 0) ? rdif0.rd_addr : rdif1.rd_addr};
      checks++;
      if (v !== '0) begin
        failures++;
        $display("FAIL %s[lat%0d] outputs: got %h required 0", name, l, v);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    for (int i = 0; i < NCHK; i++) m_vld[i] = 1'b0;
    // Empty table: done at once still scans NCHK slots and passes.
    run_scenario("empty_table", 0, 16'd0, 1'b0);
  endtask

  task automatic test_basic_pass();
    clear_table();
    write_entry(0, 1'b1, 8'h00, 8'h07, 8'hFF);
    write_entry(1, 1'b1, 8'h01, 8'h07, 8'hFF);
    mem[0] = 8'h07; mem[1] = 8'h07;
    run_scenario("basic_pass", 20, 16'd0, 1'b0);
    checks++;
    if (cycles_o[1] !== 16'd20 || pass_o[1] !== 1'b1 || o_reads[1] != "00 01 ") begin
      failures++;
      $display("FAIL basic_pass_const: got cycles=%0d pass=%b reads='%s' required 20 1 '00 01 '",
               cycles_o[1], pass_o[1], o_reads[1]);
    end
  endtask

  task automatic test_mismatch();
    mem[1] = 8'h05;
    run_scenario("mismatch", 20, 16'd0, 1'b0);
    checks++;
    if (err_vec_o[1] !== 4'b0010 || err_count_o[1] !== 3'd1 || fail_o[1] !== 1'b1) begin
      failures++;
      $display("FAIL mismatch_const: got vec=%b cnt=%0d fail=%b required 0010 1 1",
               err_vec_o[1], err_count_o[1], fail_o[1]);
    end
  endtask

  task automatic test_masked();
    clear_table();
    write_entry(0, 1'b1, 8'h10, 8'h80, 8'hF0);
    write_entry(2, 1'b1, 8'h11, 8'h3C, 8'h00);
    mem[8'h10] = 8'h85; mem[8'h11] = 8'hC3;
    run_scenario("masked", 5, 16'd0, 1'b0);
    checks++;
    if (pass_o[0] !== 1'b1 || pass_o[1] !== 1'b1 || o_busy[1] - o_busy[0] != 2) begin
      failures++;
      $display("FAIL masked_const: got pass=%b/%b scan_diff=%0d required 1/1 2",
               pass_o[0], pass_o[1], o_busy[1] - o_busy[0]);
    end
  endtask

  task automatic test_timeout();
    run_scenario("timeout50", -1, 16'd50, 1'b0);
    checks++;
    if (timeout_o[1] !== 1'b1 || cycles_o[1] !== 16'd50 || o_busy[1] != 50 || o_reads[1] != "") begin
      failures++;
      $display("FAIL timeout_const: got to=%b cycles=%0d busy=%0d reads='%s' required 1 50 50 ''",
               timeout_o[1], cycles_o[1], o_busy[1], o_reads[1]);
    end
    run_scenario("limit_eq_done", 15, 16'd15, 1'b0);
    run_scenario("limit_after_done", 15, 16'd16, 1'b0);
  endtask

  task automatic test_reset_mid_scan();
    bit seen;
    clear_table();
    write_entry(1, 1'b1, 8'h20, 8'h11, 8'hFF);
    write_entry(3, 1'b1, 8'h21, 8'h22, 8'hFF);
    @(negedge clk);
    start = 1'b1; timeout_limit = 16'd0; dut_done = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (rdif1.rd_en) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL reset_mid_scan: rd_en never seen, required a read within 50 cycles");
    end
    @(negedge clk);
    reset = 1'b1; dut_done = 1'b0;
    @(negedge clk);
    check_all_zero("reset_mid_scan");
    reset = 1'b0;
    for (int i = 0; i < NCHK; i++) m_vld[i] = 1'b0;
    run_scenario("after_reset", 0, 16'd0, 1'b0);
  endtask

  task automatic test_busy_ignore();
    clear_table();
    write_entry(0, 1'b1, 8'h30, 8'h5A, 8'hFF);
    mem[8'h30] = 8'h5A;
    run_scenario("busy_ignore", 10, 16'd0, 1'b1);
    run_scenario("busy_ignore_rerun", 10, 16'd0, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] a, e, m;
    int d;
    logic [15:0] lim;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < NCHK; i++) begin
        a = 8'($urandom); e = 8'($urandom);
        m = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
        write_entry(i, 1'($urandom_range(0, 1)), a, e, m);
        mem[a] = ($urandom_range(0, 1) == 1) ? ((e & m) | (8'($urandom) & ~m)) : 8'($urandom);
      end
      d = $urandom_range(0, 40);
      lim = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 60));
      run_scenario($sformatf("random%0d", it), d, lim, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_valid = 1'b0; dut_done = 1'b0;
    timeout_limit = '0; cfg_idx = '0; cfg_addr = '0; cfg_exp = '0; cfg_mask = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset();
    test_basic_pass();
    test_mismatch();
    test_masked();
    test_timeout();
    test_reset_mid_scan();
    test_busy_ignore();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
